// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: default sizes, the FSM
// state encoding and the lane bit-offset helper.
package mux_scan_pkg;

  localparam int NUM_INPUTS_DEF = 31;
  localparam int DATA_W_DEF     = 2;
  localparam int SEL_W_DEF      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scan_state_e;

  // LSB position of a lane inside the packed snapshot vector.
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps the mux select through every input lane, samples
// the combinational mux output into a packed snapshot and offers it
// downstream with a valid/ready handshake.
// Optional build macro MUX_SCAN_PARITY_EN adds result_parity, the XOR of all
// captured bits.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; snapshot not valid
// SETTLE  | select just changed, waiting for the mux output to settle
// CAPTURE | sample mux_out into lane mux_sel, advance select
// DONE    | snapshot valid, held until result_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_INPUTS    = NUM_INPUTS_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SEL_W         = SEL_W_DEF,
  parameter int SETTLE_CYCLES = 0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start,
  input  logic                         abort,
  output logic [SEL_W-1:0]             mux_sel,
  input  logic [DATA_W-1:0]            mux_out,
  output logic                         busy,
  output logic                         result_valid,
  input  logic                         result_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic                         result_parity,
`endif
  output logic [NUM_INPUTS*DATA_W-1:0] result_data
);

  // 4 bits covers the full 0..15 settle range.
  localparam int CNT_W = 4;

  scan_state_e                 state_q, state_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_INPUTS*DATA_W-1:0] data_q, data_d;
`ifdef MUX_SCAN_PARITY_EN
  logic                        par_q, par_d;
`endif

  // Next-state, select, settle counter and snapshot update.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef MUX_SCAN_PARITY_EN
    par_d   = par_q;
`endif

    if (abort) begin
      // Abort wins over start and over a completing handshake.
      state_d = IDLE;
      sel_d   = '0;
      cnt_d   = '0;
      data_d  = '0;
`ifdef MUX_SCAN_PARITY_EN
      par_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sel_d  = '0;
            data_d = '0;
`ifdef MUX_SCAN_PARITY_EN
            par_d  = 1'b0;
`endif
            if (SETTLE_CYCLES == 0) begin
              state_d = CAPTURE;
            end else begin
              state_d = SETTLE;
              cnt_d   = CNT_W'(SETTLE_CYCLES);
            end
          end
        end

        SETTLE: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = CAPTURE;
          end
        end

        CAPTURE: begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
              data_d[lane_lsb(i, DATA_W) +: DATA_W] = mux_out;
            end
          end
`ifdef MUX_SCAN_PARITY_EN
          par_d = par_q ^ (^mux_out);
`endif
          if (sel_q == SEL_W'(NUM_INPUTS - 1)) begin
            // Park the select on lane 0; the mux default lane is never driven.
            sel_d   = '0;
            state_d = DONE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
            if (SETTLE_CYCLES == 0) begin
              state_d = CAPTURE;
            end else begin
              state_d = SETTLE;
              cnt_d   = CNT_W'(SETTLE_CYCLES);
            end
          end
        end

        DONE: begin
          if (result_ready) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset drops any partial result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign mux_sel      = sel_q;
  assign busy         = (state_q == SETTLE) || (state_q == CAPTURE);
  assign result_valid = (state_q == DONE);
  assign result_data  = data_q;
`ifdef MUX_SCAN_PARITY_EN
  assign result_parity = par_q;
`endif

endmodule
